// File: rtl/gc_pkg.sv
// gc_pkg: shared FSM state type and default parameter values for the refresh bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } gc_state_e;

  localparam int GC_DATA_W_DEF       = 64;
  localparam int GC_DEPTH_DEF        = 128;
  localparam int GC_REF_INTERVAL_DEF = 1024;

endpackage

// File: rtl/gc_array.sv
// gc_array: DEPTH x DATA_W storage, one registered read port and one write port.
// Latency: read data valid 1 cycle after re; a same-row read-during-write returns the old word.
// Backpressure: none, one read and one write accepted every cycle.
// Ports: clk/rst (async active-low, clears only the read register), re/raddr/rdata, we/waddr/wdata.
module gc_array #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 128,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  // Storage itself is not reset; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gc_refresh_bank.sv
// gc_refresh_bank: gain-cell style bank that periodically reads and rewrites every row.
// Latency: user read data 1 cycle after u_re; an uncontended sweep takes 2*DEPTH+1 cycles.
// Backpressure: user traffic is never stalled; the sweep waits for idle read/write slots.
// Ports: clk, rst (async active-low); user write (u_we/u_waddr/u_wdata); user read
//        (u_re/u_raddr -> u_rdata/u_rvalid); sweep control/status (ref_start, ref_busy,
//        ref_row, ref_done pulse, sticky ref_miss).
module gc_refresh_bank
  import gc_pkg::*;
#(
  parameter int DATA_W       = GC_DATA_W_DEF,
  parameter int DEPTH        = GC_DEPTH_DEF,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int REF_INTERVAL = GC_REF_INTERVAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              u_we,
  input  logic [ADDR_W-1:0] u_waddr,
  input  logic [DATA_W-1:0] u_wdata,
  input  logic              u_re,
  input  logic [ADDR_W-1:0] u_raddr,
  output logic [DATA_W-1:0] u_rdata,
  output logic              u_rvalid,
  input  logic              ref_start,
  output logic              ref_busy,
  output logic [ADDR_W-1:0] ref_row,
  output logic              ref_done,
  output logic              ref_miss
);

  localparam int                TMR_W    = $clog2(REF_INTERVAL);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REF_INTERVAL - 1);

  gc_state_e         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0] ref_row_q, ref_row_d;
  logic              all_iss_q, all_iss_d;   // every row of this sweep has been issued
  logic              wb_vld_q, wb_vld_d;     // buffer owns a row (read issued)
  logic              wb_full_q, wb_full_d;   // buffer data captured, ready to write back
  logic [ADDR_W-1:0] wb_row_q, wb_row_d;
  logic [DATA_W-1:0] wb_dat_q, wb_dat_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;
  logic              miss_q, miss_d;

  logic              sweep;
  logic              tmr_wrap;
  logic              wb_drain;
  logic              wb_hit;
  logic              ref_issue;
  logic              iss_hit;
  logic              retire;
  logic [ADDR_W-1:0] retire_row;
  logic              last_retire;

  logic              arr_re;
  logic [ADDR_W-1:0] arr_raddr;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  assign sweep    = (state_q == ST_SWEEP);
  assign tmr_wrap = (timer_q == TMR_LAST);

  // Writeback only uses a write slot the user left free.
  assign wb_drain = wb_vld_q && wb_full_q && !u_we;

  // A user write to the buffered row makes the buffered copy stale. The buffer
  // counts as owning the row from the read cycle onward, so a write landing while
  // the data is still in the array's read register is caught here too.
  assign wb_hit = wb_vld_q && u_we && (u_waddr == wb_row_q);

  // Only one row is in the read/writeback path at a time; a new refresh read may
  // overlap the writeback of the previous row. A user read of the same row
  // piggybacks on the single array read.
  assign ref_issue = sweep && !all_iss_q &&
                     (!u_re || (u_raddr == ref_row_q)) &&
                     (!wb_vld_q || wb_drain);

  // User write to the row being refresh-read: the fresh user data supersedes it.
  assign iss_hit = ref_issue && u_we && (u_waddr == ref_row_q);

  // Drain needs u_we=0, both cancels need u_we=1, so at most one retire per cycle.
  assign retire      = wb_drain || wb_hit || iss_hit;
  assign retire_row  = iss_hit ? ref_row_q : wb_row_q;
  assign last_retire = sweep && retire && (retire_row == LAST_ROW);

  assign arr_re    = u_re || ref_issue;
  assign arr_raddr = u_re ? u_raddr : ref_row_q;
  assign arr_we    = u_we || wb_drain;
  assign arr_waddr = u_we ? u_waddr : wb_row_q;
  assign arr_wdata = u_we ? u_wdata : wb_dat_q;

  gc_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .re    (arr_re),
    .raddr (arr_raddr),
    .rdata (arr_rdata),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = tmr_wrap ? '0 : timer_q + TMR_W'(1);
    ref_row_d = ref_row_q;
    all_iss_d = all_iss_q;
    wb_vld_d  = wb_vld_q;
    wb_full_d = wb_full_q;
    wb_row_d  = wb_row_q;
    wb_dat_d  = wb_dat_q;
    rvalid_d  = u_re;
    done_d    = 1'b0;
    miss_d    = miss_q | (sweep && tmr_wrap);

    case (state_q)
      ST_IDLE: begin
        ref_row_d = '0;
        all_iss_d = 1'b0;
        if (ref_start || tmr_wrap) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        // ref_start is deliberately ignored while sweeping.
        if (ref_issue) begin
          ref_row_d = ref_row_q + ADDR_W'(1);
          if (ref_row_q == LAST_ROW) all_iss_d = 1'b1;
        end
        if (last_retire) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          ref_row_d = '0;
          all_iss_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture the refresh read one cycle after it was issued.
    if (wb_vld_q && !wb_full_q) begin
      wb_dat_d  = arr_rdata;
      wb_full_d = 1'b1;
    end
    if (wb_drain || wb_hit) wb_vld_d = 1'b0;
    if (ref_issue && !iss_hit) begin
      wb_vld_d  = 1'b1;
      wb_full_d = 1'b0;
      wb_row_d  = ref_row_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      ref_row_q <= '0;
      all_iss_q <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_full_q <= 1'b0;
      wb_row_q  <= '0;
      wb_dat_q  <= '0;
      rvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ref_row_q <= ref_row_d;
      all_iss_q <= all_iss_d;
      wb_vld_q  <= wb_vld_d;
      wb_full_q <= wb_full_d;
      wb_row_q  <= wb_row_d;
      wb_dat_q  <= wb_dat_d;
      rvalid_q  <= rvalid_d;
      done_q    <= done_d;
      miss_q    <= miss_d;
    end
  end

  assign u_rdata  = arr_rdata;
  assign u_rvalid = rvalid_q;
  assign ref_busy = sweep;
  assign ref_row  = ref_row_q;
  assign ref_done = done_q;
  assign ref_miss = miss_q;

endmodule

// File: tb/tb_gc_refresh_bank.sv
// tb_gc_refresh_bank: directed bench for gc_refresh_bank.
// dut_a: DEPTH=16 user traffic, sweeps, piggyback, cancel, reset; dut_b: DEPTH=8 stall;
// dut_c: DEPTH=16 REF_INTERVAL=40 deadline overrun. dut_b and dut_c share stimulus.
module tb_gc_refresh_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_we, a_re, a_start;
  logic [3:0]  a_waddr, a_raddr;
  logic [15:0] a_wdata;
  logic [15:0] a_rdata;
  logic        a_rvalid, a_busy, a_done, a_miss;
  logic [3:0]  a_row;

  logic        s_we, s_re, s_start;
  logic [3:0]  s_waddr, s_raddr;
  logic [15:0] s_wdata;
  logic [15:0] b_rdata, c_rdata;
  logic        b_rvalid, b_busy, b_done, b_miss;
  logic        c_rvalid, c_busy, c_done, c_miss;
  logic [2:0]  b_row;
  logic [3:0]  c_row;

  gc_refresh_bank #(.DATA_W(16), .DEPTH(16), .REF_INTERVAL(4096)) dut_a (
    .clk(clk), .rst(rst),
    .u_we(a_we), .u_waddr(a_waddr), .u_wdata(a_wdata),
    .u_re(a_re), .u_raddr(a_raddr), .u_rdata(a_rdata), .u_rvalid(a_rvalid),
    .ref_start(a_start), .ref_busy(a_busy), .ref_row(a_row),
    .ref_done(a_done), .ref_miss(a_miss)
  );

  gc_refresh_bank #(.DATA_W(16), .DEPTH(8), .REF_INTERVAL(4096)) dut_b (
    .clk(clk), .rst(rst),
    .u_we(s_we), .u_waddr(s_waddr[2:0]), .u_wdata(s_wdata),
    .u_re(s_re), .u_raddr(s_raddr[2:0]), .u_rdata(b_rdata), .u_rvalid(b_rvalid),
    .ref_start(s_start), .ref_busy(b_busy), .ref_row(b_row),
    .ref_done(b_done), .ref_miss(b_miss)
  );

  gc_refresh_bank #(.DATA_W(16), .DEPTH(16), .REF_INTERVAL(40)) dut_c (
    .clk(clk), .rst(rst),
    .u_we(s_we), .u_waddr(s_waddr), .u_wdata(s_wdata),
    .u_re(s_re), .u_raddr(s_raddr), .u_rdata(c_rdata), .u_rvalid(c_rvalid),
    .ref_start(s_start), .ref_busy(c_busy), .ref_row(c_row),
    .ref_done(c_done), .ref_miss(c_miss)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] model_a [16];

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [3:0]  raddr;
    logic        exp_vld;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_a(input string name);
    for (int i = 0; i < 16; i++) begin
      a_re    = 1'b1;
      a_raddr = 4'(i);
      step();
      chk({name, "_vld"}, a_rvalid, 1);
      chk(name, a_rdata, model_a[i]);
    end
    a_re = 1'b0;
  endtask

  task automatic pulse_start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  initial begin
    int n;
    int piggy;
    int ph;
    int e;
    logic prev_re;
    logic saw_b_done;

    vecs[0] = '{1'b1, 4'd0,  16'h1111, 1'b0, 4'd0,  1'b0, 16'h0000};
    vecs[1] = '{1'b1, 4'd1,  16'h2222, 1'b1, 4'd0,  1'b1, 16'h1111};
    vecs[2] = '{1'b1, 4'd0,  16'hAAAA, 1'b1, 4'd0,  1'b1, 16'h1111};
    vecs[3] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd0,  1'b1, 16'hAAAA};
    vecs[4] = '{1'b1, 4'd2,  16'h3333, 1'b1, 4'd1,  1'b1, 16'h2222};
    vecs[5] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd2,  1'b1, 16'h3333};
    vecs[6] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  1'b1, 16'hC003};
    vecs[7] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd15, 1'b1, 16'hC00F};
    vecs[8] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b0, 16'h0000};

    rst = 1'b1;
    a_we = 0; a_re = 0; a_start = 0; a_waddr = 0; a_raddr = 0; a_wdata = 0;
    s_we = 0; s_re = 0; s_start = 0; s_waddr = 0; s_raddr = 0; s_wdata = 0;
    #1 rst = 1'b0;
    #1;
    chk("rst_rdata", a_rdata, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_row", a_row, 0);
    chk("rst_done", a_done, 0);
    chk("rst_miss", a_miss, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Known contents in every row.
    for (int i = 0; i < 16; i++) begin
      a_we = 1'b1; a_waddr = 4'(i); a_wdata = 16'hC000 + 16'(i);
      model_a[i] = 16'hC000 + 16'(i);
      step();
    end
    a_we = 1'b0;

    // Table-driven user read/write traffic while idle.
    for (int i = 0; i < 9; i++) begin
      a_we = vecs[i].we; a_waddr = vecs[i].waddr; a_wdata = vecs[i].wdata;
      a_re = vecs[i].re; a_raddr = vecs[i].raddr;
      if (vecs[i].we) model_a[vecs[i].waddr] = vecs[i].wdata;
      step();
      chk($sformatf("vec%0d_rvalid", i), a_rvalid, vecs[i].exp_vld);
      if (vecs[i].exp_vld) chk($sformatf("vec%0d_rdata", i), a_rdata, vecs[i].exp_dat);
      chk($sformatf("vec%0d_busy", i), a_busy, 0);
    end
    a_we = 1'b0; a_re = 1'b0;

    // Idle sweep, with a ref_start during the sweep that must be ignored.
    pulse_start_a();
    chk("idle_busy", a_busy, 1);
    chk("idle_row0", a_row, 0);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      a_start = (i == 5);
      step();
      if (a_done) begin n = i; break; end
    end
    a_start = 1'b0;
    chk("idle_sweep_len", n, 33);
    step();
    chk("idle_done_pulse", a_done, 0);
    chk("idle_back_idle", a_busy, 0);
    chk("idle_row_zero", a_row, 0);
    read_all_a("idle_data");

    // Piggyback: user reads row 5 while the sweep sits on row 5.
    pulse_start_a();
    n = 0; piggy = 0;
    for (int i = 1; i <= 200; i++) begin
      if (a_row == 4'd5 && piggy < 2) begin
        a_re = 1'b1; a_raddr = 4'd5; piggy++;
      end else begin
        a_re = 1'b0;
      end
      prev_re = a_re;
      step();
      if (prev_re) begin
        chk("piggy_rvalid", a_rvalid, 1);
        chk("piggy_rdata", a_rdata, model_a[5]);
      end
      if (a_done) begin n = i; break; end
    end
    a_re = 1'b0;
    chk("piggy_dwell", piggy, 2);
    chk("piggy_sweep_len", n, 33);
    read_all_a("piggy_data");

    // Cancel: write the buffered row 9, then the row being refresh-read (10).
    pulse_start_a();
    n = 0; ph = 0;
    for (int i = 1; i <= 200; i++) begin
      a_we = 1'b0;
      if (ph == 1) begin
        a_we = 1'b1; a_waddr = 4'd10; a_wdata = 16'h5A5A; model_a[10] = 16'h5A5A; ph = 2;
      end else if (ph == 0 && a_row == 4'd10) begin
        a_we = 1'b1; a_waddr = 4'd9; a_wdata = 16'hA5A5; model_a[9] = 16'hA5A5; ph = 1;
      end
      step();
      if (a_done) begin n = i; break; end
    end
    a_we = 1'b0;
    chk("cancel_sweep_len", n, 32);
    read_all_a("cancel_data");

    // Reset in the middle of a sweep.
    pulse_start_a();
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      if (a_row == 4'd3) begin n = i; break; end
      step();
    end
    chk("mid_reached_row3", (n > 0), 1);
    a_re = 1'b1; a_raddr = 4'd0;
    step();
    a_re = 1'b0;
    chk("mid_pre_rvalid", a_rvalid, 1);
    chk("mid_pre_busy", a_busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rdata", a_rdata, 0);
    chk("mid_rst_rvalid", a_rvalid, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_row", a_row, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_miss", a_miss, 0);
    #1 rst = 1'b1;
    pulse_start_a();
    chk("mid_restart_busy", a_busy, 1);
    chk("mid_restart_row", a_row, 0);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (a_done) begin n = i; break; end
    end
    chk("mid_restart_len", n, 33);

    // Stall (dut_b) and deadline overrun (dut_c) under continuous reads of row 0.
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    e = 0;
    s_we = 1'b1; s_waddr = 4'd0; s_wdata = 16'h1234;
    step(); e++;
    s_we = 1'b0;
    s_start = 1'b1; s_re = 1'b1; s_raddr = 4'd0;
    step(); e++;
    s_start = 1'b0;
    saw_b_done = 1'b0;
    while (e < 60) begin
      step(); e++;
      if (b_done) saw_b_done = 1'b1;
      if (e == 39) chk("c_miss_before_wrap", c_miss, 0);
      if (e == 40) chk("c_miss_at_wrap", c_miss, 1);
    end
    chk("b_stall_busy", b_busy, 1);
    chk("b_stall_row", b_row, 1);
    chk("b_stall_no_done", saw_b_done, 0);
    chk("b_no_miss", b_miss, 0);
    chk("b_stall_rdata", b_rdata, 16'h1234);
    chk("c_stall_busy", c_busy, 1);
    chk("c_stall_row", c_row, 1);
    chk("c_stall_rdata", c_rdata, 16'h1234);
    s_re = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (b_done) begin n = i; break; end
    end
    chk("b_release_len", n, 15);
    step();
    chk("b_release_idle", b_busy, 0);
    repeat (40) step();
    chk("c_miss_sticky", c_miss, 1);
    s_re = 1'b1; s_raddr = 4'd0;
    step();
    s_re = 1'b0;
    chk("b_row0_kept", b_rdata, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gc_refresh_bank.md
GC_REFRESH_BANK -- requirements
Module: gc_refresh_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 64, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, number of rows; must be a power of two and at least 4.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), row address width.
REQ-004 SHALL have parameter REF_INTERVAL, default 1024, refresh deadline period in cycles; must be greater than 2*DEPTH.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  sole clock
- rst  in  1  asynchronous active-low reset
- u_we  in  1  user write enable
- u_waddr  in  ADDR_W  user write row
- u_wdata  in  DATA_W  user write data
- u_re  in  1  user read enable
- u_raddr  in  ADDR_W  user read row
- u_rdata  out  DATA_W  user read data
- u_rvalid  out  1  u_rdata valid
- ref_start  in  1  one-cycle request for an early sweep
- ref_busy  out  1  sweep in progress
- ref_row  out  ADDR_W  row the sweep targets next
- ref_done  out  1  one-cycle pulse when a sweep completes
- ref_miss  out  1  sticky flag: refresh deadline overrun

Function
REQ-007 SHALL instantiate one array with a synchronous registered read port and a write port; same-row read-during-write SHALL return the old data.
REQ-008 User access SHALL always have priority, with no stalls: u_rdata and u_rvalid SHALL be valid exactly 1 cycle after u_re.
REQ-009 The FSM SHALL have states IDLE and SWEEP.
- IDLE -> SWEEP: on ref_start, or on interval-timer wrap.
- SWEEP -> IDLE: when all DEPTH rows are retired, with ref_done asserted for that one cycle.
REQ-010 ref_start received in SWEEP SHALL be ignored.
REQ-011 The interval timer SHALL run freely from 0 to REF_INTERVAL-1 and wrap; a wrap in SWEEP SHALL set ref_miss, and ref_miss SHALL stay set until reset.
REQ-012 A sweep SHALL visit rows 0 to DEPTH-1 in order; ref_row SHALL advance by one per row issued and SHALL be 0 in IDLE.
REQ-013 Refresh read of ref_row SHALL issue only when:
- u_re=0, or u_raddr==ref_row (piggyback: one array read serves both), and
- the writeback buffer is empty or is draining that cycle.
REQ-014 Read data SHALL be captured one cycle later into a single-entry writeback buffer that holds data, row and a valid flag.
REQ-015 Buffer writeback SHALL occur only in a cycle with u_we=0.
REQ-016 If a user write hits the buffered row, or hits the row being refresh-read in that cycle, the refresh writeback for that row SHALL be cancelled and the row counted as retired.
REQ-017 A row SHALL be retired on writeback or on cancel; the sweep completes when row DEPTH-1 is retired and the buffer is empty.
REQ-018 In any cycle, at most one array read and at most one array write SHALL occur.
REQ-019 A sweep under continuous user traffic to rows other than ref_row SHALL stall indefinitely without corrupting data.

Reset
REQ-020 While rst=0, the following SHALL be 0: u_rdata, u_rvalid, ref_busy, ref_row, ref_done, ref_miss, the timer, and the buffer valid flag; the FSM SHALL be in IDLE.
REQ-021 Reset during SWEEP SHALL abort the sweep without a writeback; array contents SHALL be unspecified.

Structure
REQ-022 Package gc_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-023 The array SHALL be a separate sub-module gc_array, parametrised by DATA_W and DEPTH.

Verification
REQ-024 Idle sweep: ref_start with no user traffic -> ref_done exactly 2*DEPTH+1 cycles later; all rows unchanged.
REQ-025 Piggyback: during SWEEP, u_re on row 5 while ref_row=5 -> u_rdata correct next cycle; row 5 written back with the same data; no extra read.
REQ-026 Write-hit cancel: buffer holds row 9; u_we row 9 with 0xA5A5 -> no writeback of row 9; later read returns 0xA5A5.
REQ-027 Stall: u_re on row 0 every cycle with DEPTH=8 -> sweep stalls at row 1 with ref_busy=1; releasing u_re lets the sweep finish and pulse ref_done.
REQ-028 Deadline: REF_INTERVAL=40, DEPTH=16, continuous reads of another row -> ref_miss=1 at the first wrap after the sweep starts.
REQ-029 Reset mid-sweep: rst=0 at ref_row=3 -> all outputs 0 asynchronously; after release, ref_start gives a full sweep from row 0.
